// File: rtl/mlaccel_pkg.sv
// mlaccel_pkg: shared command codes, default widths and loader state encoding.
package mlaccel_pkg;
    localparam int MEM_AW_DEF  = 17;
    localparam int CODE_AW_DEF = 11;

    localparam logic [7:0] CMD_NOP   = 8'h00;
    localparam logic [7:0] CMD_WDATA = 8'h01;
    localparam logic [7:0] CMD_WCODE = 8'h02;
    localparam logic [7:0] CMD_EXEC  = 8'h03;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        CODE,
        EXEC_ISSUE,
        EXEC_WAIT0,
        EXEC_WAIT
    } loader_state_t;

    // WRITE_DATA carries a 24-bit address; the other commands a 16-bit one.
    function automatic logic [2:0] hdr_len(input logic [1:0] cmd);
        return (cmd == CMD_WDATA[1:0]) ? 3'd5 : 3'd4;
    endfunction
endpackage

// File: rtl/mlaccel_loader_shift.sv
// mlaccel_loader_shift: 8-byte MSB-first shift register with byte count and word-done flag.
module mlaccel_loader_shift (
    input  logic        clock,
    input  logic        resetn,
    input  logic        clear,
    input  logic        shift,
    input  logic [7:0]  din,
    output logic [63:0] word_next,
    output logic [2:0]  count,
    output logic        done
);
    // Only seven bytes are kept; the eighth is consumed straight from din.
    logic [55:0] word;

    assign word_next = {word, din};
    assign done      = shift && (count == 3'd7);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            word  <= '0;
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (shift) begin
            word  <= word_next[55:0];
            count <= count + 3'd1;
        end
    end
endmodule

// File: rtl/mlaccel_loader.sv
// mlaccel_loader: parses the host byte stream into memory writes, code-store writes and execute launches.
module mlaccel_loader
    import mlaccel_pkg::*;
#(
    parameter int MEM_AW  = MEM_AW_DEF,
    parameter int CODE_AW = CODE_AW_DEF
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               mem_wen,
    output logic [MEM_AW-1:0]  mem_addr,
    output logic [7:0]         mem_wdata,
    output logic [CODE_AW-1:0] ctrl_addr,
    output logic [CODE_AW-1:0] ctrl_execute,
    input  logic               ctrl_busy,
    output logic [3:0]         ctrl_wen_coeff,
    output logic               ctrl_wen_opcode,
    output logic [31:0]        ctrl_wdata_coeff,
    output logic [31:0]        ctrl_wdata_opcode,
    output logic               busy,
    output logic               err
);
    loader_state_t      state, state_nxt;
    logic [1:0]         cmd;
    logic [15:0]        left;
    logic [MEM_AW-1:0]  daddr;
    logic [CODE_AW-1:0] caddr;
    logic               accept, hdr_last, sh_clear, sh_shift, word_done;
    logic [63:0]        word_next;
    logic [2:0]         count;
    logic [15:0]        hdr_n;
    logic [CODE_AW-1:0] hdr_code_a;
    logic [MEM_AW-1:0]  hdr_mem_a;

    mlaccel_loader_shift u_shift (
        .clock     (clock),
        .resetn    (resetn),
        .clear     (sh_clear),
        .shift     (sh_shift),
        .din       (in_data),
        .word_next (word_next),
        .count     (count),
        .done      (word_done)
    );

    assign in_ready   = (state == IDLE) || (state == HDR) || (state == DATA) || (state == CODE);
    assign busy       = (state != IDLE);
    assign accept     = in_valid && in_ready;
    assign hdr_last   = (state == HDR) && accept && (count == hdr_len(cmd) - 3'd1);
    assign hdr_n      = word_next[15:0];
    assign hdr_code_a = word_next[CODE_AW+15:16];
    assign hdr_mem_a  = word_next[MEM_AW+15:16];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        sh_clear  = 1'b0;
        sh_shift  = 1'b0;
        case (state)
            IDLE: begin
                sh_clear  = accept;
                state_nxt = (accept && in_data != CMD_NOP && in_data <= CMD_EXEC) ? HDR : IDLE;
            end
            HDR: begin
                sh_shift = accept && !hdr_last;
                sh_clear = hdr_last;
                if (hdr_last)
                    state_nxt = (cmd == CMD_WDATA[1:0]) ? ((hdr_n != 16'd0) ? DATA : IDLE) :
                                (cmd == CMD_WCODE[1:0]) ? ((hdr_n != 16'd0) ? CODE : IDLE) :
                                (hdr_n[CODE_AW-1:0] != '0) ? EXEC_ISSUE : IDLE;
            end
            DATA:       state_nxt = (accept && left == 16'd1) ? IDLE : DATA;
            CODE: begin
                sh_shift  = accept;
                state_nxt = (word_done && left == 16'd1) ? IDLE : CODE;
            end
            EXEC_ISSUE: state_nxt = EXEC_WAIT0;
            EXEC_WAIT0: state_nxt = EXEC_WAIT;
            EXEC_WAIT:  state_nxt = ctrl_busy ? EXEC_WAIT : IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Strobes are single-cycle; address/data outputs hold their last values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cmd               <= '0;
            left              <= '0;
            daddr             <= '0;
            caddr             <= '0;
            err               <= 1'b0;
            mem_wen           <= 1'b0;
            mem_addr          <= '0;
            mem_wdata         <= '0;
            ctrl_addr         <= '0;
            ctrl_execute      <= '0;
            ctrl_wen_coeff    <= '0;
            ctrl_wen_opcode   <= 1'b0;
            ctrl_wdata_coeff  <= '0;
            ctrl_wdata_opcode <= '0;
        end else begin
            mem_wen         <= 1'b0;
            ctrl_wen_coeff  <= 4'b0000;
            ctrl_wen_opcode <= 1'b0;
            ctrl_execute    <= '0;
            if (state == IDLE && accept) begin
                cmd <= in_data[1:0];
                err <= err || (in_data > CMD_EXEC);
            end
            if (hdr_last) begin
                left  <= hdr_n;
                daddr <= hdr_mem_a;
                caddr <= hdr_code_a;
                if (cmd == CMD_EXEC[1:0] && hdr_n[CODE_AW-1:0] != '0) begin
                    ctrl_addr    <= hdr_code_a;
                    ctrl_execute <= hdr_n[CODE_AW-1:0];
                end
            end
            if (state == DATA && accept) begin
                mem_wen   <= 1'b1;
                mem_addr  <= daddr;
                mem_wdata <= in_data;
                daddr     <= daddr + 1'b1;
                left      <= left - 16'd1;
            end
            if (state == CODE && word_done) begin
                ctrl_wen_coeff    <= 4'b1111;
                ctrl_wen_opcode   <= 1'b1;
                ctrl_addr         <= caddr;
                ctrl_wdata_coeff  <= word_next[63:32];
                ctrl_wdata_opcode <= word_next[31:0];
                caddr             <= caddr + 1'b1;
                left              <= left - 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_mlaccel_loader.sv
// tb_mlaccel_loader: directed and randomized command streams checked every cycle
// against a byte-level parser model of the loader.
module tb_mlaccel_loader;
    logic        clock = 1'b0, resetn = 1'b1, in_valid = 1'b0, ctrl_busy = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, mem_wen, ctrl_wen_opcode, busy, err;
    logic [16:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [10:0] ctrl_addr, ctrl_execute;
    logic [3:0]  ctrl_wen_coeff;
    logic [31:0] ctrl_wdata_coeff, ctrl_wdata_opcode;

    mlaccel_loader dut (
        .clock             (clock),
        .resetn            (resetn),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_ready          (in_ready),
        .mem_wen           (mem_wen),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .ctrl_addr         (ctrl_addr),
        .ctrl_execute      (ctrl_execute),
        .ctrl_busy         (ctrl_busy),
        .ctrl_wen_coeff    (ctrl_wen_coeff),
        .ctrl_wen_opcode   (ctrl_wen_opcode),
        .ctrl_wdata_coeff  (ctrl_wdata_coeff),
        .ctrl_wdata_opcode (ctrl_wdata_opcode),
        .busy              (busy),
        .err               (err)
    );

    always #5 clock = ~clock;

    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: walks the accepted byte stream command by command.
    int          mode = 0, ph = 0, left = 0, ma = 0, ca = 0;
    logic [7:0]  cmdm = 8'h00;
    logic [7:0]  hq[$], wq[$];
    logic        e_mem_wen = 0, e_wen = 0, e_err = 0;
    logic [16:0] e_mem_addr = 0;
    logic [7:0]  e_mem_wdata = 0;
    logic [10:0] e_ctrl_addr = 0, e_exec = 0;
    logic [31:0] e_coeff = 0, e_opc = 0;

    task automatic model_byte(input logic [7:0] b);
        logic [63:0] w;
        int need;
        w = 64'd0;
        if (mode == 0) begin
            if (b >= 8'h01 && b <= 8'h03) begin
                cmdm = b;
                hq.delete();
                mode = 1;
            end else if (b != 8'h00) e_err = 1'b1;
        end else if (mode == 1) begin
            hq.push_back(b);
            need = (cmdm == 8'h01) ? 5 : 4;
            if (hq.size() == need) begin
                foreach (hq[i]) w = (w << 8) | 64'(hq[i]);
                left = int'(w[15:0]);
                if (cmdm == 8'h01) begin
                    ma = int'(w[39:16]) % 131072;
                    mode = (left != 0) ? 2 : 0;
                end else if (cmdm == 8'h02) begin
                    ca = int'(w[31:16]) % 2048;
                    wq.delete();
                    mode = (left != 0) ? 3 : 0;
                end else begin
                    mode = 0;
                    if (left % 2048 != 0) begin
                        e_ctrl_addr = 11'(int'(w[31:16]) % 2048);
                        e_exec = 11'(left % 2048);
                        ph = 1;
                    end
                end
            end
        end else if (mode == 2) begin
            e_mem_wen = 1'b1;
            e_mem_addr = 17'(ma);
            e_mem_wdata = b;
            ma = (ma + 1) % 131072;
            left--;
            if (left == 0) mode = 0;
        end else begin
            wq.push_back(b);
            if (wq.size() == 8) begin
                foreach (wq[i]) w = (w << 8) | 64'(wq[i]);
                e_wen = 1'b1;
                e_ctrl_addr = 11'(ca);
                e_coeff = w[63:32];
                e_opc = w[31:0];
                ca = (ca + 1) % 2048;
                wq.delete();
                left--;
                if (left == 0) mode = 0;
            end
        end
    endtask

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mode = 0; ph = 0; left = 0; ma = 0; ca = 0; cmdm = 8'h00;
            hq.delete(); wq.delete();
            e_mem_wen = 0; e_wen = 0; e_err = 0; e_mem_addr = 0; e_mem_wdata = 0;
            e_ctrl_addr = 0; e_exec = 0; e_coeff = 0; e_opc = 0;
        end else begin
            e_mem_wen = 1'b0;
            e_wen = 1'b0;
            e_exec = 11'd0;
            if (ph == 1) ph = 2;
            else if (ph == 2) ph = 3;
            else if (ph == 3) begin
                if (!ctrl_busy) ph = 0;
            end else if (in_valid) model_byte(in_data);
        end
    end

    // Per-cycle comparison plus logs of what the DUT actually wrote.
    bit          chk_on = 0;
    logic [7:0]  mem[int];
    logic [63:0] code[int];
    int          n_mem = 0, n_code = 0, n_ex = 0, run = 0, last_run = 0;
    logic [16:0] pa_prev = 0, pa_last = 0;
    logic [10:0] ex_val = 0, ex_addr = 0;

    always @(negedge clock) begin
        if (chk_on) begin
            chk("in_ready", 64'(in_ready), 64'(ph == 0));
            chk("busy", 64'(busy), 64'(mode != 0 || ph != 0));
            chk("err", 64'(err), 64'(e_err));
            chk("mem_wen", 64'(mem_wen), 64'(e_mem_wen));
            chk("mem_addr", 64'(mem_addr), 64'(e_mem_addr));
            chk("mem_wdata", 64'(mem_wdata), 64'(e_mem_wdata));
            chk("ctrl_addr", 64'(ctrl_addr), 64'(e_ctrl_addr));
            chk("ctrl_execute", 64'(ctrl_execute), 64'(e_exec));
            chk("ctrl_wen_coeff", 64'(ctrl_wen_coeff), e_wen ? 64'hF : 64'h0);
            chk("ctrl_wen_opcode", 64'(ctrl_wen_opcode), 64'(e_wen));
            chk("ctrl_wdata_coeff", 64'(ctrl_wdata_coeff), 64'(e_coeff));
            chk("ctrl_wdata_opcode", 64'(ctrl_wdata_opcode), 64'(e_opc));
            chk("strobe_while_busy", 64'(ctrl_busy && (mem_wen || ctrl_wen_opcode)), 64'd0);
            if (mem_wen) begin
                mem[int'(mem_addr)] = mem_wdata;
                pa_prev = pa_last;
                pa_last = mem_addr;
                n_mem++;
            end
            if (ctrl_wen_opcode) begin
                code[int'(ctrl_addr)] = {ctrl_wdata_coeff, ctrl_wdata_opcode};
                n_code++;
            end
            if (ctrl_execute != 11'd0) begin
                n_ex++;
                ex_val = ctrl_execute;
                ex_addr = ctrl_addr;
            end
            if (!in_ready) run++;
            else begin
                if (run != 0) last_run = run;
                run = 0;
            end
        end
    end

    // Compute stub: holds ctrl_busy for busy_len cycles after each execute pulse.
    int busy_len = 0, busy_left = 0;
    always @(posedge clock) begin
        #2;
        if (ctrl_execute != 11'd0) busy_left = busy_len;
        ctrl_busy = (busy_left > 0);
        if (busy_left > 0) busy_left--;
    end

    logic [7:0] sq[$];
    bit gaps_on = 0;

    task automatic send_sq();
        foreach (sq[i]) begin
            int g;
            bit r;
            g = 0;
            while (gaps_on && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_data = 8'($urandom);
                @(posedge clock); #1;
            end
            in_valid = 1'b1;
            in_data = sq[i];
            do begin
                @(negedge clock);
                r = in_ready;
                @(posedge clock); #1;
                g++;
            end while (!r && g < 200);
            if (!r) chk("handshake_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
        end
        sq.delete();
    endtask

    task automatic settle();
        int k;
        k = 0;
        while ((busy || ctrl_busy) && k < 300) begin
            @(posedge clock); #1;
            k++;
        end
        if (k >= 300) chk("settle_timeout", 64'd1, 64'd0);
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic build_rand();
        int k, n;
        logic [31:0] a;
        k = $urandom_range(0, 9);
        a = $urandom;
        if (k == 0) sq.push_back(8'h00);
        else if (k == 1) sq.push_back(8'($urandom_range(4, 255)));
        else if (k <= 4) begin
            n = $urandom_range(0, 6);
            sq.push_back(8'h01);
            sq.push_back(a[23:16]); sq.push_back(a[15:8]); sq.push_back(a[7:0]);
            sq.push_back(8'(n >> 8)); sq.push_back(8'(n));
            repeat (n) sq.push_back(8'($urandom));
        end else if (k <= 7) begin
            n = $urandom_range(0, 3);
            sq.push_back(8'h02);
            sq.push_back(a[15:8]); sq.push_back(a[7:0]);
            sq.push_back(8'(n >> 8)); sq.push_back(8'(n));
            repeat (n * 8) sq.push_back(8'($urandom));
        end else begin
            n = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 40);
            busy_len = $urandom_range(0, 8);
            sq.push_back(8'h03);
            sq.push_back(a[15:8]); sq.push_back(a[7:0]);
            sq.push_back(8'(n >> 8)); sq.push_back(8'(n));
        end
    endtask

    initial begin
        #2 resetn = 1'b0;
        #1 chk_on = 1;
        repeat (3) @(posedge clock);
        #1 resetn = 1'b1;

        // Reset in the middle of a code word.
        sq = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_sq();
        resetn = 1'b0;
        @(negedge clock);
        chk("t1_in_ready", 64'(in_ready), 64'd1);
        chk("t1_busy", 64'(busy), 64'd0);
        chk("t1_wen", 64'({ctrl_wen_coeff, ctrl_wen_opcode, mem_wen}), 64'd0);
        chk("t1_ctrl_addr", 64'(ctrl_addr), 64'd0);
        @(posedge clock); #1 resetn = 1'b1;
        n_code = 0;
        sq = '{8'h00};
        send_sq();
        repeat (12) @(posedge clock);
        #1;
        chk("t1_code_writes", 64'(n_code), 64'd0);
        chk("t1_idle", 64'(busy), 64'd0);

        sq = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h01, 8'h02, 8'h04, 8'h08};
        send_sq();
        settle();
        chk("t2_mem_word", 64'({mem[3], mem[2], mem[1], mem[0]}), 64'h08040201);
        chk("t2_mem_count", 64'(n_mem), 64'd4);

        sq = '{8'h02, 8'h00, 8'h03, 8'h00, 8'h02,
               8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h23,
               8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h04, 8'h00, 8'h22};
        send_sq();
        settle();
        chk("t3_code3", code[3], 64'h04030201_00000023);
        chk("t3_code4", code[4], 64'h04030201_00040022);
        chk("t3_code_count", 64'(n_code), 64'd2);

        busy_len = 10;
        sq = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h12};
        send_sq();
        settle();
        chk("t4_exec_pulses", 64'(n_ex), 64'd1);
        chk("t4_exec_len", 64'(ex_val), 64'h012);
        chk("t4_exec_addr", 64'(ex_addr), 64'd0);
        chk("t4_ready_low_cycles", 64'(last_run), 64'd11);

        sq = '{8'h01, 8'h01, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'hAA, 8'hBB};
        send_sq();
        settle();
        chk("t5_addr_first", 64'(pa_prev), 64'h1FFFF);
        chk("t5_addr_wrap", 64'(pa_last), 64'h00000);
        chk("t5_data_wrap", 64'(mem[0]), 64'hBB);
        sq = '{8'h03, 8'h00, 8'h05, 8'h00, 8'h00};
        send_sq();
        chk("t5_l0_idle", 64'(busy), 64'd0);
        chk("t5_l0_ready", 64'(in_ready), 64'd1);
        settle();
        chk("t5_l0_no_pulse", 64'(n_ex), 64'd1);

        n_mem = 0;
        n_code = 0;
        sq = '{8'h7E, 8'h00};
        send_sq();
        settle();
        chk("t6_err", 64'(err), 64'd1);
        chk("t6_no_strobes", 64'(n_mem + n_code), 64'd0);

        gaps_on = 1;
        repeat (60) begin
            build_rand();
            send_sq();
        end
        settle();
        chk("err_sticky", 64'(err), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end
endmodule
